rlbp_readout_fifo: RTL and testbench

- Downstream consumer of the rlbp_macro serial result stream (clk_o, start_o, data_o, done_o).
- Deserializes each LBP code of CODE_W bits and tags it with a 4-bit frame counter.
- Buffers tagged codes in a small FIFO that firmware drains through a simple pop interface on the Wishbone clock domain.
- Raises an interrupt when the buffer reaches a programmable fill level.

---
 rtl/rlbp_readout_fifo.sv | 189 ++++++++++++++++++
 tb/tb_rlbp_readout_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rlbp_readout_fifo.sv
// Readout buffer for the rlbp_macro serial result stream: deserializes LBP codes,
// tags each one with a 4-bit frame counter and queues it for a firmware pop interface.
module rlbp_readout_fifo #(
    parameter int CODE_W = 12,  // must not exceed 16 so the code stays clear of the tag field
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          ser_clk_i,
    input  logic          ser_start_i,
    input  logic          ser_data_i,
    input  logic          ser_done_i,
    input  logic          rd_en_i,
    input  logic          clr_i,
    input  logic [AW:0]   irq_thr_i,
    output logic [31:0]   rd_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    output logic          partial_o,
    output logic          irq_o
);

    localparam int ENTRY_W = CODE_W + 4;
    localparam int CW      = $clog2(CODE_W + 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    // sync_p0/p1 carry {done, data, start, clk}; edge_p2 carries {done, start, clk}
    logic [3:0] sync_p0, sync_p1;
    logic [2:0] edge_p2;
    logic       clk_rise, start_rise, done_rise, data_bit;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            edge_p2 <= '0;
        end else begin
            sync_p0 <= {ser_done_i, ser_data_i, ser_start_i, ser_clk_i};
            sync_p1 <= sync_p0;
            edge_p2 <= {sync_p1[3], sync_p1[1], sync_p1[0]};
        end
    end

    assign clk_rise   = sync_p1[0] & ~edge_p2[0];
    assign start_rise = sync_p1[1] & ~edge_p2[1];
    assign done_rise  = sync_p1[3] & ~edge_p2[2];
    assign data_bit   = sync_p1[2];

    // ---- deserializer ----
    logic [0:0]         state_q;
    logic [CODE_W-1:0]  shift_q, shift_nxt;
    logic [CW-1:0]      cnt_q, cnt_nxt;
    logic [3:0]         tag_q;
    logic               word_done;
    logic               push_pend_q;
    logic [ENTRY_W-1:0] push_word_q;
    logic               partial_q;

    always_comb begin
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        word_done = 1'b0;
        if (state_q == ST_CAPTURE && clk_rise) begin
            shift_nxt = {shift_q[CODE_W-2:0], data_bit};
            if (cnt_q == CW'(CODE_W - 1)) begin
                cnt_nxt   = '0;
                word_done = 1'b1;
            end else begin
                cnt_nxt = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            push_pend_q <= 1'b0;
            push_word_q <= '0;
            partial_q   <= 1'b0;
        end else if (clr_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            push_pend_q <= 1'b0;
            partial_q   <= 1'b0;
        end else begin
            push_pend_q <= word_done;
            if (word_done)
                push_word_q <= {tag_q, shift_nxt};
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_q <= ST_CAPTURE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    // The bit on a coincident clock edge is shifted before done/start look at the count
                    shift_q <= shift_nxt;
                    cnt_q   <= cnt_nxt;
                    if (done_rise) begin
                        if (cnt_nxt != '0)
                            partial_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        tag_q   <= tag_q + 4'd1;
                    end else if (start_rise) begin
                        if (cnt_nxt != '0)
                            partial_q <= 1'b1;
                        cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    // ---- FIFO ----
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic               overflow_q, irq_q;
    logic               fifo_empty, fifo_full, push, pop, wr_ok;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW+1)'(DEPTH));
    assign push       = push_pend_q && !clr_i;
    assign pop        = rd_en_i && !fifo_empty && !clr_i;
    assign wr_ok      = push && (!fifo_full || pop);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_ptr_q] <= push_word_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= (irq_thr_i != '0) && (level_q >= irq_thr_i);
            if (clr_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (wr_ok)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && !wr_ok)
                    overflow_q <= 1'b1;
                case ({wr_ok, pop})
                    2'b10:   level_q <= level_q + (AW+1)'(1);
                    2'b01:   level_q <= level_q - (AW+1)'(1);
                    default: level_q <= level_q;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_o               = '0;
        rd_data_o[CODE_W-1:0]   = mem[rd_ptr_q][CODE_W-1:0];
        rd_data_o[19:16]        = mem[rd_ptr_q][ENTRY_W-1:CODE_W];
    end

    assign empty_o    = fifo_empty;
    assign full_o     = fifo_full;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign partial_o  = partial_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_rlbp_readout_fifo.sv
// Directed bench for rlbp_readout_fifo: drives a slow serial stream and checks
// the popped words, fill flags, sticky flags and interrupt against hand-computed values.
module tb_rlbp_readout_fifo;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        ser_clk_i, ser_start_i, ser_data_i, ser_done_i;
    logic        rd_en_i, clr_i;
    logic [3:0]  irq_thr_i;
    logic [31:0] rd_data_o;
    logic        empty_o, full_o, overflow_o, partial_o, irq_o;
    logic [3:0]  level_o;

    int errors = 0;
    int checks = 0;

    rlbp_readout_fifo #(.CODE_W(12), .DEPTH(8), .AW(3)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .ser_clk_i  (ser_clk_i),
        .ser_start_i(ser_start_i),
        .ser_data_i (ser_data_i),
        .ser_done_i (ser_done_i),
        .rd_en_i    (rd_en_i),
        .clr_i      (clr_i),
        .irq_thr_i  (irq_thr_i),
        .rd_data_o  (rd_data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .partial_o  (partial_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_n    = 1'b0;
        ser_clk_i   = 1'b0;
        ser_start_i = 1'b0;
        ser_data_i  = 1'b0;
        ser_done_i  = 1'b0;
        rd_en_i     = 1'b0;
        clr_i       = 1'b0;
        wait_neg(2);
        wb_rst_n = 1'b1;
        wait_neg(2);
    endtask

    // pop_sync raises rd_en_i for exactly the cycle in which the resulting push lands
    task automatic send_bit(input logic b, input bit pop_sync);
        ser_data_i = b;
        wait_neg(4);
        ser_clk_i = 1'b1;
        if (pop_sync) begin
            wait_neg(3);
            rd_en_i = 1'b1;
            wait_neg(1);
            rd_en_i = 1'b0;
            wait_neg(2);
        end else begin
            wait_neg(6);
        end
        ser_clk_i = 1'b0;
        wait_neg(4);
    endtask

    task automatic send_code(input logic [11:0] c, input bit pop_last);
        for (int i = 11; i >= 1; i--)
            send_bit(c[i], 1'b0);
        send_bit(c[0], pop_last);
    endtask

    task automatic pulse_start();
        ser_start_i = 1'b1;
        wait_neg(4);
        ser_start_i = 1'b0;
        wait_neg(4);
    endtask

    task automatic pulse_done();
        ser_done_i = 1'b1;
        wait_neg(4);
        ser_done_i = 1'b0;
        wait_neg(4);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        chk(tag, rd_data_o, exp);
        rd_en_i = 1'b1;
        wait_neg(1);
        rd_en_i = 1'b0;
    endtask

    initial begin
        wb_rst_n    = 1'b0;
        ser_clk_i   = 1'b0;
        ser_start_i = 1'b0;
        ser_data_i  = 1'b0;
        ser_done_i  = 1'b0;
        rd_en_i     = 1'b0;
        clr_i       = 1'b0;
        irq_thr_i   = 4'd0;

        // reset state
        wait_neg(2);
        chk("rst_level", level_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_partial", partial_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rd_data", rd_data_o, 32'h0);
        wb_rst_n = 1'b1;
        wait_neg(2);

        // single frame, one code
        pulse_start();
        send_code(12'b1010_1100_0011, 1'b0);
        pulse_done();
        chk("t1_level", level_o, 1);
        chk("t1_empty", empty_o, 0);
        chk("t1_data", rd_data_o, 32'h0000_0AC3);
        chk("t1_partial", partial_o, 0);

        // two frames, two codes each, tag advances per frame
        do_reset();
        pulse_start();
        send_code(12'hFFF, 1'b0);
        send_code(12'h001, 1'b0);
        pulse_done();
        pulse_start();
        send_code(12'h123, 1'b0);
        send_code(12'h456, 1'b0);
        pulse_done();
        chk("t2_level", level_o, 4);
        pop_check("t2_pop0", 32'h0000_0FFF);
        pop_check("t2_pop1", 32'h0000_0001);
        pop_check("t2_pop2", 32'h0001_0123);
        pop_check("t2_pop3", 32'h0001_0456);
        chk("t2_empty", empty_o, 1);
        chk("t2_level_end", level_o, 0);

        // overflow: nine codes, no pops
        do_reset();
        pulse_start();
        for (int i = 0; i < 9; i++)
            send_code(12'h100 + 12'(i), 1'b0);
        chk("t3_full", full_o, 1);
        chk("t3_level", level_o, 8);
        chk("t3_overflow", overflow_o, 1);
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("t3_pop%0d", i), 32'h0000_0100 + 32'(i));
        chk("t3_empty", empty_o, 1);
        chk("t3_level_end", level_o, 0);
        chk("t3_overflow_sticky", overflow_o, 1);

        // clr together with rd_en flushes and clears flags
        clr_i   = 1'b1;
        rd_en_i = 1'b1;
        wait_neg(1);
        clr_i   = 1'b0;
        rd_en_i = 1'b0;
        wait_neg(1);
        chk("t3_clr_overflow", overflow_o, 0);
        chk("t3_clr_empty", empty_o, 1);

        // full FIFO with a simultaneous push and pop
        pulse_start();
        for (int i = 0; i < 8; i++)
            send_code(12'h200 + 12'(i), 1'b0);
        chk("t6_full", full_o, 1);
        chk("t6_level", level_o, 8);
        chk("t6_overflow_pre", overflow_o, 0);
        send_code(12'h208, 1'b1);
        chk("t6_level_pp", level_o, 8);
        chk("t6_overflow_pp", overflow_o, 0);
        for (int i = 1; i < 9; i++)
            pop_check($sformatf("t6_pop%0d", i), 32'h0000_0200 + 32'(i));
        chk("t6_empty", empty_o, 1);

        // partial frame: done after 5 bits
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++)
            send_bit(i[0], 1'b0);
        pulse_done();
        chk("t4_partial", partial_o, 1);
        chk("t4_level", level_o, 0);
        pulse_start();
        send_code(12'h5A5, 1'b0);
        pulse_done();
        chk("t4_level_next", level_o, 1);
        pop_check("t4_tag_next", 32'h0001_05A5);

        // interrupt threshold
        do_reset();
        irq_thr_i = 4'd3;
        pulse_start();
        send_code(12'h00A, 1'b0);
        send_code(12'h00B, 1'b0);
        chk("t5_level2", level_o, 2);
        chk("t5_irq_below", irq_o, 0);
        send_code(12'h00C, 1'b0);
        pulse_done();
        chk("t5_level3", level_o, 3);
        chk("t5_irq_at", irq_o, 1);
        rd_en_i = 1'b1;
        wait_neg(1);
        rd_en_i = 1'b0;
        chk("t5_level_pop", level_o, 2);
        chk("t5_irq_lag", irq_o, 1);
        wait_neg(1);
        chk("t5_irq_drop", irq_o, 0);

        // clr with rd_en while holding entries and a partial flag
        pulse_start();
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0);
        pulse_done();
        chk("t7_partial_set", partial_o, 1);
        clr_i   = 1'b1;
        rd_en_i = 1'b1;
        wait_neg(1);
        clr_i   = 1'b0;
        rd_en_i = 1'b0;
        chk("t7_level", level_o, 0);
        chk("t7_empty", empty_o, 1);
        chk("t7_partial", partial_o, 0);
        chk("t7_overflow", overflow_o, 0);
        wait_neg(1);
        chk("t7_irq", irq_o, 0);

        // asynchronous reset in the middle of a capture
        irq_thr_i = 4'd1;
        pulse_start();
        send_code(12'h321, 1'b0);
        send_code(12'h654, 1'b0);
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0);
        chk("t8_level_pre", level_o, 2);
        chk("t8_irq_pre", irq_o, 1);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("t8_level", level_o, 0);
        chk("t8_empty", empty_o, 1);
        chk("t8_full", full_o, 0);
        chk("t8_irq", irq_o, 0);
        chk("t8_partial", partial_o, 0);
        chk("t8_overflow", overflow_o, 0);
        chk("t8_rd_data", rd_data_o, 32'h0);
        wait_neg(1);
        wb_rst_n = 1'b1;
        ser_clk_i = 1'b0;
        wait_neg(2);
        send_code(12'hFFF, 1'b0);
        chk("t8_idle_ignores", level_o, 0);
        pulse_start();
        send_code(12'h789, 1'b0);
        pulse_done();
        chk("t8_after_level", level_o, 1);
        chk("t8_after_data", rd_data_o, 32'h0000_0789);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
